rtc_time_writer: RTL and testbench
==================================

# rtc_time_writer

Downstream of the time-edit stage, this block takes the edited BCD time (hours, minutes, seconds, AM/PM, 12/24 h format) and writes it into the external RTC chip. It uses that chip's multiplexed address/data bus. On a commit request it range-checks the time, then runs a fixed sequence of bus write transactions: seconds, minutes, hours, and optionally a transfer command. It reports busy, done and error status back to the control FSM.

## Interface
- T_ADDR, 4, cycles ALE/address phase lasts (1..255)
- T_DATA, 4, cycles WR/data phase lasts (1..255)
- T_GAP, 2, idle cycles after each transaction (1..255)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- commit  in  1  start request; sampled only in IDLE
- HC  in  8  hours, BCD
- MC  in  8  minutes, BCD
- SC  in  8  seconds, BCD
- AmPm  in  1  1 = PM (12 h mode only)
- format  in  1  1 = 12 h, 0 = 24 h
- ad_out  out  8  address/data bus drive value
- ad_oe  out  1  bus output enable
- cs_n  out  1  chip select, active low
- ale  out  1  address latch enable, active high
- wr_n  out  1  write strobe, active low
- rd_n  out  1  read strobe; held 1
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, sequence finished
- err  out  1  one-cycle pulse, input rejected

## Operation
- Reset values: ad_out=0x00, ad_oe=0, cs_n=1, ale=0, wr_n=1, rd_n=1, busy=0, done=0, err=0. The FSM is in IDLE.
- FSM states: IDLE, CHECK, ADDR, DATA, GAP, DONE.
- IDLE: when commit=1, latch HC/MC/SC/AmPm/format and go to CHECK. Input changes after the latch have no effect.
- CHECK (1 cycle): validate the latched time.
  - Every low nibble must be ≤9.
  - SC and MC must be ≤0x59.
  - 24 h mode: HC must be ≤0x23.
  - 12 h mode: HC must be in 0x01..0x12.
  - On failure: err=1 for this cycle only, no bus activity, next state IDLE.
  - On success: index=0, next state ADDR.
- Transaction table (index: address, data):
  - 0: 0x21, SC.
  - 1: 0x22, MC.
  - 2: 0x23, hour byte.
  - 3: 0xF2, 0x00 (only with the macro; see Configuration).
- Hour byte:
  - 24 h mode: {2'b00, HC[5:0]}.
  - 12 h mode: {1'b1, 1'b0, AmPm, HC[4:0]}.
- ADDR (T_ADDR cycles): cs_n=0, ale=1, wr_n=1, ad_oe=1, ad_out=address.
- DATA (T_DATA cycles): cs_n=0, ale=0, wr_n=0, ad_oe=1, ad_out=data.
- GAP (T_GAP cycles): cs_n=1, ale=0, wr_n=1, ad_oe=0, ad_out=0x00. Afterwards, if more transactions remain, index+1 and go to ADDR; else go to DONE.
- DONE (1 cycle): done=1, busy=0, bus idle; next state IDLE.
- busy=1 in CHECK, ADDR, DATA and GAP; busy=0 in IDLE and DONE.
- Phase counter is 8 bits and reloads at every phase entry.

## Timing
- Edge k samples commit=1 in IDLE. CHECK occupies cycle k+1. The first ADDR cycle begins at edge k+2.
- All bus outputs are registered; no combinational path from inputs to outputs.
- One transaction lasts T_ADDR+T_DATA+T_GAP cycles (10 at defaults).
- Commit-to-done latency, edge to done pulse: 2 + N·(T_ADDR+T_DATA+T_GAP), where N is the number of transactions. At defaults: 32 cycles with N=3, 42 with N=4.
- Boundary conditions:
  - commit during busy or DONE is ignored; it is not queued.
  - If commit is still high in the IDLE cycle after DONE, a new sequence starts.
  - Reset asserted in any state returns all outputs to reset values at the next edge, including mid-DATA, where cs_n and wr_n rise immediately. No partial transaction resumes.
  - ale and wr_n are never low/high simultaneously: ale=1 and wr_n=0 never occur in the same cycle.

## Configuration
- RTC_TRANSFER_EN defined: N=4. After the hours write, transaction 3 writes address 0xF2 with data 0x00, which commits the RTC time registers.
- RTC_TRANSFER_EN undefined: N=3. The sequence ends after the hours write, and no 0xF2 access is ever generated.

## Test plan
- 24 h, HC=0x23, MC=0x59, SC=0x58, commit 1 cycle:
  - bus shows (0x21,0x58), (0x22,0x59), (0x23,0x23).
  - done pulses 32 cycles after the commit edge; err stays 0.
- 12 h, HC=0x12, AmPm=1, MC=SC=0x00:
  - hour data byte is 0xB2.
  - 12 h, HC=0x00 instead: err pulses in the CHECK cycle and cs_n stays 1.
- MC=0x60, or SC=0x1A: err=1 for exactly one cycle, busy returns to 0, and no ale/cs_n activity occurs.
- Second commit pulse during the first sequence's DATA phase: exactly 3 transactions appear, and there is a single done pulse.
- Reset asserted during the second transaction's DATA phase:
  - next edge shows cs_n=1, wr_n=1, ad_oe=0, busy=0.
  - no further bus activity occurs until a new commit.
- RTC_TRANSFER_EN defined, valid 24 h time: a 4th transaction (0xF2,0x00) appears, and done arrives at 42 cycles.

Source files
------------

// File: rtl/rtc_time_writer_if.sv
// ---------------------------------------------------------------------------
// rtc_time_writer_if
// Multiplexed address/data bus of the external RTC chip.
//   ad_out  8  address/data drive value
//   ad_oe   1  bus output enable
//   cs_n    1  chip select, active low
//   ale     1  address latch enable, active high
//   wr_n    1  write strobe, active low
//   rd_n    1  read strobe, active low
// master: the writer that drives the bus; slave: the RTC side.
// ---------------------------------------------------------------------------
interface rtc_time_writer_if;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       ale;
  logic       wr_n;
  logic       rd_n;

  modport master (output ad_out, ad_oe, cs_n, ale, wr_n, rd_n);
  modport slave  (input  ad_out, ad_oe, cs_n, ale, wr_n, rd_n);
endinterface

// File: rtl/rtc_time_writer.sv
// ---------------------------------------------------------------------------
// rtc_time_writer
// Range-checks an edited BCD time and writes it into the external RTC chip
// as a fixed sequence of bus writes: seconds (0x21), minutes (0x22),
// hours (0x23) and, when RTC_TRANSFER_EN is defined, a transfer command
// (0xF2 <- 0x00) that commits the RTC time registers.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   commit              start request, sampled only while idle
//   HC, MC, SC          hours / minutes / seconds, BCD
//   AmPm, format        1 = PM; 1 = 12 h mode, 0 = 24 h mode
//   bus                 RTC bus (master side), all outputs registered
//   busy, done, err     status: sequence running, finished pulse, reject pulse
// Parameters: T_ADDR / T_DATA / T_GAP = cycles of address, data, gap phase.
// Optional feature macro: RTC_TRANSFER_EN.
// ---------------------------------------------------------------------------
module rtc_time_writer #(
  parameter int T_ADDR = 4,
  parameter int T_DATA = 4,
  parameter int T_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  commit,
  input  logic [7:0]            HC,
  input  logic [7:0]            MC,
  input  logic [7:0]            SC,
  input  logic                  AmPm,
  input  logic                  format,
  rtc_time_writer_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, GAP, DONE} state_t;

`ifdef RTC_TRANSFER_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  localparam logic [7:0] LOAD_ADDR = 8'(T_ADDR - 1);
  localparam logic [7:0] LOAD_DATA = 8'(T_DATA - 1);
  localparam logic [7:0] LOAD_GAP  = 8'(T_GAP - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] idx_reg, idx_next;
  logic [7:0] hc_reg, mc_reg, sc_reg;
  logic       ampm_reg, fmt_reg;

  logic       time_ok;
  logic [7:0] hour_byte;
  logic [7:0] txn_addr, txn_data;

  logic [7:0] ad_out_next;
  logic       ad_oe_next, cs_n_next, ale_next, wr_n_next;
  logic       busy_next, done_next, err_next;

  // Validation of the latched time.
  always_comb begin
    time_ok = (sc_reg[3:0] <= 4'd9) && (mc_reg[3:0] <= 4'd9) &&
              (hc_reg[3:0] <= 4'd9) &&
              (sc_reg <= 8'h59) && (mc_reg <= 8'h59);
    if (fmt_reg)
      time_ok = time_ok && (hc_reg >= 8'h01) && (hc_reg <= 8'h12);
    else
      time_ok = time_ok && (hc_reg <= 8'h23);
  end

  assign hour_byte = fmt_reg ? {2'b10, ampm_reg, hc_reg[4:0]}
                             : {2'b00, hc_reg[5:0]};

  // Transaction table.
  always_comb begin
    txn_addr = 8'h00;
    txn_data = 8'h00;
    case (idx_reg)
      2'd0:    begin txn_addr = 8'h21; txn_data = sc_reg;    end
      2'd1:    begin txn_addr = 8'h22; txn_data = mc_reg;    end
      2'd2:    begin txn_addr = 8'h23; txn_data = hour_byte; end
      default: begin txn_addr = 8'hF2; txn_data = 8'h00;     end
    endcase
  end

  // State register, phase counter, transaction index and input latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'h00;
      idx_reg   <= 2'd0;
      hc_reg    <= 8'h00;
      mc_reg    <= 8'h00;
      sc_reg    <= 8'h00;
      ampm_reg  <= 1'b0;
      fmt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (state_reg == IDLE && commit) begin
        hc_reg   <= HC;
        mc_reg   <= MC;
        sc_reg   <= SC;
        ampm_reg <= AmPm;
        fmt_reg  <= format;
      end
    end
  end

  // Next-state logic; the counter is reloaded on every phase entry.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE:  if (commit) state_next = CHECK;
      CHECK: begin
        if (time_ok) begin
          state_next = ADDR;
          idx_next   = 2'd0;
          cnt_next   = LOAD_ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      ADDR: begin
        if (cnt_reg == 8'h00) begin
          state_next = DATA;
          cnt_next   = LOAD_DATA;
        end else cnt_next = cnt_reg - 8'h01;
      end
      DATA: begin
        if (cnt_reg == 8'h00) begin
          state_next = GAP;
          cnt_next   = LOAD_GAP;
        end else cnt_next = cnt_reg - 8'h01;
      end
      GAP: begin
        if (cnt_reg != 8'h00) begin
          cnt_next = cnt_reg - 8'h01;
        end else if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = ADDR;
          idx_next   = idx_reg + 2'd1;
          cnt_next   = LOAD_ADDR;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode of the current state; registered below so every output
  // comes straight from a flop.
  always_comb begin
    ad_out_next = 8'h00;
    ad_oe_next  = 1'b0;
    cs_n_next   = 1'b1;
    ale_next    = 1'b0;
    wr_n_next   = 1'b1;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      CHECK: begin
        busy_next = 1'b1;
        err_next  = !time_ok;
      end
      ADDR: begin
        busy_next   = 1'b1;
        cs_n_next   = 1'b0;
        ale_next    = 1'b1;
        ad_oe_next  = 1'b1;
        ad_out_next = txn_addr;
      end
      DATA: begin
        busy_next   = 1'b1;
        cs_n_next   = 1'b0;
        wr_n_next   = 1'b0;
        ad_oe_next  = 1'b1;
        ad_out_next = txn_data;
      end
      GAP:     busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ad_out <= 8'h00;
      bus.ad_oe  <= 1'b0;
      bus.cs_n   <= 1'b1;
      bus.ale    <= 1'b0;
      bus.wr_n   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      bus.ad_out <= ad_out_next;
      bus.ad_oe  <= ad_oe_next;
      bus.cs_n   <= cs_n_next;
      bus.ale    <= ale_next;
      bus.wr_n   <= wr_n_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
    end
  end

  assign bus.rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_time_writer.sv
// ---------------------------------------------------------------------------
// tb_rtc_time_writer
// Drives directed and random commits and compares the observed RTC bus
// transactions, status pulses and their timing against a reference model
// computed from BCD arithmetic. Honours RTC_TRANSFER_EN.
// ---------------------------------------------------------------------------
module tb_rtc_time_writer;
  localparam int TA = 4;
  localparam int TD = 4;
  localparam int TG = 2;
`ifdef RTC_TRANSFER_EN
  localparam int N = 4;
`else
  localparam int N = 3;
`endif
  localparam int DONE_LAT = 2 + N * (TA + TD + TG);

  logic       clk = 1'b0;
  logic       reset;
  logic       commit;
  logic [7:0] HC, MC, SC;
  logic       AmPm, format;
  logic       busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;

  rtc_time_writer_if bus_if ();

  rtc_time_writer #(.T_ADDR(TA), .T_DATA(TD), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset), .commit(commit),
    .HC(HC), .MC(MC), .SC(SC), .AmPm(AmPm), .format(format),
    .bus(bus_if), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // BCD byte holding a decimal value in [lo, hi].
  function automatic bit bcd_in(input logic [7:0] b, input int lo, input int hi);
    int t, o;
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    return (t <= 9) && (o <= 9) && (t * 10 + o >= lo) && (t * 10 + o <= hi);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // One commit followed by observation of the whole response.
  // second_at: cycle to pulse commit again (0 = none).
  // reset_at:  cycle to assert reset (0 = none).
  task automatic run_seq(input logic [7:0] hc, input logic [7:0] mc, input logic [7:0] sc,
                         input logic ampm, input logic fmt,
                         input int second_at, input int reset_at);
    bit         ok;
    int         exp_n, n_obs, ale_cyc, wr_cyc, done_cnt, done_at, err_cnt, err_at;
    int         cs_low, cs_after_rst, viol, limit;
    logic [7:0] exp_addr [4];
    logic [7:0] exp_data [4];
    logic [7:0] obs_addr [8];
    logic [7:0] obs_data [8];
    logic       prev_ale, prev_wr_n;

    ok = bcd_in(sc, 0, 59) && bcd_in(mc, 0, 59) &&
         (fmt ? bcd_in(hc, 1, 12) : bcd_in(hc, 0, 23));
    exp_n = ok ? N : 0;
    exp_addr[0] = 8'h21; exp_data[0] = sc;
    exp_addr[1] = 8'h22; exp_data[1] = mc;
    exp_addr[2] = 8'h23;
    exp_data[2] = fmt ? (8'h80 | (8'(ampm) << 5) | (hc & 8'h1F)) : (hc & 8'h3F);
    exp_addr[3] = 8'hF2; exp_data[3] = 8'h00;

    n_obs = 0; ale_cyc = 0; wr_cyc = 0; done_cnt = 0; done_at = -1;
    err_cnt = 0; err_at = -1; cs_low = 0; cs_after_rst = 0; viol = 0;
    prev_ale = 1'b0; prev_wr_n = 1'b1;
    limit = DONE_LAT + 10;

    HC = hc; MC = mc; SC = sc; AmPm = ampm; format = fmt; commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
    // Scramble the inputs: the latched copy must be used.
    HC = ~hc; MC = ~mc; SC = ~sc; AmPm = ~ampm; format = ~fmt;

    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      if (reset_at != 0 && c == reset_at + 1) begin
        check("rst_cs_n", bus_if.cs_n, 1'b1);
        check("rst_wr_n", bus_if.wr_n, 1'b1);
        check("rst_ad_oe", bus_if.ad_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
      end
      if (c == 1) check("busy_check", busy, 1'b1);
      if (c == 2) check("busy_after_check", busy, ok);
      if (bus_if.ale && !prev_ale) begin
        if (n_obs < 8) obs_addr[n_obs] = bus_if.ad_out;
        n_obs++;
      end
      if (!bus_if.wr_n && prev_wr_n && n_obs > 0 && n_obs <= 8)
        obs_data[n_obs-1] = bus_if.ad_out;
      if (!bus_if.wr_n && n_obs > 0 && n_obs <= 8 && bus_if.ad_out !== obs_data[n_obs-1])
        viol++;
      if (bus_if.ale) begin
        ale_cyc++;
        if (bus_if.cs_n || !bus_if.ad_oe || !bus_if.wr_n) viol++;
      end
      if (!bus_if.wr_n) begin
        wr_cyc++;
        if (bus_if.cs_n || !bus_if.ad_oe) viol++;
      end
      if (!bus_if.rd_n) viol++;
      if (!bus_if.cs_n) begin
        cs_low++;
        if (reset_at != 0 && c > reset_at) cs_after_rst++;
      end
      if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
      if (err)  begin err_cnt++;  if (err_at < 0) err_at = c;   end
      prev_ale  = bus_if.ale;
      prev_wr_n = bus_if.wr_n;
      commit = (second_at != 0 && c == second_at);
      if (reset_at != 0 && c == reset_at) reset = 1'b1;
    end
    commit = 1'b0;

    $display("[TB] txn hc=%02h mc=%02h sc=%02h pm=%0d fmt=%0d -> txns=%0d done@%0d err@%0d",
             hc, mc, sc, ampm, fmt, n_obs, done_at, err_at);
    for (int i = 0; i < n_obs && i < 8; i++)
      $display("[TB]   bus write %0d: addr=%02h data=%02h", i, obs_addr[i], obs_data[i]);

    check("bus_protocol", viol, 0);
    if (reset_at != 0) begin
      check("no_bus_after_reset", cs_after_rst, 0);
      check("no_done_after_reset", done_cnt, 0);
    end else begin
      check("n_txn", n_obs, exp_n);
      for (int i = 0; i < exp_n && i < n_obs; i++) begin
        check($sformatf("addr%0d", i), obs_addr[i], exp_addr[i]);
        check($sformatf("data%0d", i), obs_data[i], exp_data[i]);
      end
      check("ale_cycles", ale_cyc, exp_n * TA);
      check("wr_cycles", wr_cyc, exp_n * TD);
      check("done_count", done_cnt, ok);
      check("err_count", err_cnt, !ok);
      if (ok) check("done_latency", done_at, DONE_LAT);
      else begin
        check("err_cycle", err_at, 1);
        check("cs_idle_on_err", cs_low, 0);
      end
    end
  endtask

  initial begin
    logic [7:0] h, m, s;
    logic       p, f;
    reset = 1'b1; commit = 1'b0;
    HC = 8'h00; MC = 8'h00; SC = 8'h00; AmPm = 1'b0; format = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ad_out", bus_if.ad_out, 8'h00);
    check("reset_ad_oe", bus_if.ad_oe, 1'b0);
    check("reset_cs_n", bus_if.cs_n, 1'b1);
    check("reset_ale", bus_if.ale, 1'b0);
    check("reset_wr_n", bus_if.wr_n, 1'b1);
    check("reset_rd_n", bus_if.rd_n, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_seq(8'h23, 8'h59, 8'h58, 1'b0, 1'b0, 0, 0);   // 24 h upper bounds
    run_seq(8'h12, 8'h00, 8'h00, 1'b1, 1'b1, 0, 0);   // 12 h PM, hour byte 0xB2
    run_seq(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0, 0);   // 12 h hour 0 rejected
    run_seq(8'h10, 8'h60, 8'h00, 1'b0, 1'b0, 0, 0);   // minutes out of range
    run_seq(8'h10, 8'h00, 8'h1A, 1'b0, 1'b0, 0, 0);   // bad seconds nibble
    run_seq(8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 0, 0);   // 24 h hour 24 rejected
    run_seq(8'h01, 8'h30, 8'h15, 1'b0, 1'b1, 0, 0);   // 12 h AM lower bound
    run_seq(8'h08, 8'h45, 8'h30, 1'b0, 1'b0, 7, 0);   // extra commit in DATA
    run_seq(8'h17, 8'h05, 8'h09, 1'b0, 1'b0, 0, 17);  // reset in 2nd DATA
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 24; t++) begin
      f = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end else begin
        h = f ? to_bcd(int'($urandom_range(1, 12))) : to_bcd(int'($urandom_range(0, 23)));
        m = to_bcd(int'($urandom_range(0, 59)));
        s = to_bcd(int'($urandom_range(0, 59)));
      end
      run_seq(h, m, s, p, f, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
